riscv_lsu: RTL and testbench

RISCV_LSU -- requirements
Module: riscv_lsu

---
 rtl/riscv_lsu.sv | 165 ++++++++++++++++
 tb/tb_riscv_lsu.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_lsu.sv
// RISC-V load/store unit: one outstanding access, lane-aligned memory port,
// sign/zero-extended load results and a single-cycle response pulse.
module riscv_lsu #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 9,
  parameter int MEM_LAT = 2
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  req_valid,
  output logic                                  req_ready,
  input  logic                                  req_we,
  input  logic [2:0]                            req_funct3,
  input  logic [ADDR_W-1:0]                     req_addr,
  input  logic [DATA_W-1:0]                     req_wdata,
  input  logic [4:0]                            req_rd,
  input  logic                                  flush,
  output logic                                  busy,
  output logic                                  resp_valid,
  output logic                                  resp_wen,
  output logic [4:0]                            resp_rd,
  output logic [DATA_W-1:0]                     resp_data,
  output logic                                  resp_err,
  output logic                                  mem_wr,
  output logic                                  mem_rd,
  output logic [ADDR_W-$clog2(DATA_W/8)-1:0]    mem_addr,
  output logic [DATA_W/8-1:0]                   mem_be,
  output logic [DATA_W-1:0]                     mem_wdata,
  input  logic [DATA_W-1:0]                     mem_rdata
);

  localparam int NB    = DATA_W / 8;
  localparam int OFF_W = $clog2(NB);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

  state_t              r_state;
  logic [2:0]          r_cnt;
  logic                r_we;
  logic [2:0]          r_f3;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [4:0]          r_rd;
  logic                r_err;
  logic [DATA_W-1:0]   r_rdata;

  logic                w_accept;
  logic                w_err;
  logic                w_access;
  logic                w_resp;
  logic                w_load_ok;

  function automatic logic access_err(input logic we, input logic [2:0] f3,
                                      input logic [OFF_W-1:0] off);
    logic       illegal;
    logic [2:0] off3;
    logic [2:0] msk;
    illegal = (f3 == 3'b111) || (we && f3[2]) ||
              ((DATA_W == 32) && ((f3 == 3'b011) || (f3 == 3'b110)));
    off3    = 3'(off);
    msk     = 3'((4'd1 << f3[1:0]) - 4'd1);
    return illegal || (|(off3 & msk));
  endfunction

  function automatic logic [NB-1:0] lane_be(input logic [1:0] sz, input logic [OFF_W-1:0] off);
    logic [NB-1:0] m;
    case (sz)
      2'd0:    m = NB'(1);
      2'd1:    m = NB'(3);
      2'd2:    m = NB'(15);
      default: m = '1;
    endcase
    return m << off;
  endfunction

  function automatic logic [DATA_W-1:0] lane_wdata(input logic [DATA_W-1:0] d, input logic [1:0] sz,
                                                   input logic [OFF_W-1:0] off);
    logic [DATA_W-1:0] keep;
    for (int i = 0; i < DATA_W; i++) keep[i] = ((i / 8) < (1 << sz));
    return (d & keep) << {off, 3'b000};
  endfunction

  function automatic logic [DATA_W-1:0] load_ext(input logic [DATA_W-1:0] raw, input logic [2:0] f3,
                                                 input logic [OFF_W-1:0] off);
    logic [DATA_W-1:0] sh;
    logic [DATA_W-1:0] res;
    logic              sgn;
    int                nbits;
    sh    = raw >> {off, 3'b000};
    nbits = 8 << f3[1:0];
    sgn   = 1'b0;
    for (int i = 0; i < DATA_W; i++) if (i == nbits - 1) sgn = sh[i] & ~f3[2];
    for (int i = 0; i < DATA_W; i++) res[i] = (i < nbits) ? sh[i] : sgn;
    return res;
  endfunction

  assign w_accept = req_valid && req_ready;
  assign w_err    = access_err(req_we, req_funct3, req_addr[OFF_W-1:0]);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE:   if (w_accept) r_state <= w_err ? RESP : ACCESS;
        // the strobe of an ACCESS cycle is always issued; flush only drops the response
        ACCESS: begin
          if (flush) begin
            r_state <= IDLE;
          end else if (r_we) begin
            r_state <= RESP;
          end else begin
            r_state <= WAIT;
            r_cnt   <= 3'(MEM_LAT - 1);
          end
        end
        WAIT: begin
          if (flush) begin
            r_state <= IDLE;
            r_cnt   <= '0;
          end else if (r_cnt == '0) begin
            r_state <= RESP;
          end else begin
            r_cnt   <= r_cnt - 3'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_we    <= req_we;
      r_f3    <= req_funct3;
      r_addr  <= req_addr;
      r_wdata <= req_wdata;
      r_rd    <= req_rd;
      r_err   <= w_err;
    end
    if ((r_state == WAIT) && (r_cnt == '0)) r_rdata <= mem_rdata;
  end

  // all outputs decode from registered state, so reset clears them immediately
  assign w_access  = (r_state == ACCESS);
  assign w_resp    = (r_state == RESP) && !flush;
  assign w_load_ok = w_resp && !r_err && !r_we;

  assign req_ready = reset && (r_state == IDLE) && !flush;
  assign busy      = (r_state != IDLE);

  assign mem_wr    = w_access && r_we;
  assign mem_rd    = w_access && !r_we;
  assign mem_addr  = w_access ? r_addr[ADDR_W-1:OFF_W] : '0;
  assign mem_be    = w_access ? lane_be(r_f3[1:0], r_addr[OFF_W-1:0]) : '0;
  assign mem_wdata = w_access ? lane_wdata(r_wdata, r_f3[1:0], r_addr[OFF_W-1:0]) : '0;

  assign resp_valid = w_resp;
  assign resp_err   = w_resp && r_err;
  assign resp_wen   = w_load_ok && (r_rd != 5'd0);
  assign resp_rd    = w_resp ? r_rd : '0;
  assign resp_data  = w_load_ok ? load_ext(r_rdata, r_f3, r_addr[OFF_W-1:0]) : '0;

endmodule

// File: tb/tb_riscv_lsu.sv
// Scoreboard bench for riscv_lsu: byte-array reference memory predicts strobes
// and responses; a negedge monitor pops and compares whatever the DUT presents.
module tb_riscv_lsu;
  localparam int DW  = 32;
  localparam int AW  = 9;
  localparam int ML  = 2;
  localparam int NB  = DW / 8;
  localparam int WAW = AW - 2;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic           req_valid = 1'b0;
  logic           req_we = 1'b0;
  logic [2:0]     req_funct3 = '0;
  logic [AW-1:0]  req_addr = '0;
  logic [DW-1:0]  req_wdata = '0;
  logic [4:0]     req_rd = '0;
  logic           flush = 1'b0;
  logic [DW-1:0]  mem_rdata = '0;
  logic           req_ready, busy, resp_valid, resp_wen, resp_err, mem_wr, mem_rd;
  logic [4:0]     resp_rd;
  logic [DW-1:0]  resp_data, mem_wdata;
  logic [WAW-1:0] mem_addr;
  logic [NB-1:0]  mem_be;

  riscv_lsu #(.DATA_W(DW), .ADDR_W(AW), .MEM_LAT(ML)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_rd(req_rd), .flush(flush), .busy(busy),
    .resp_valid(resp_valid), .resp_wen(resp_wen), .resp_rd(resp_rd),
    .resp_data(resp_data), .resp_err(resp_err), .mem_wr(mem_wr), .mem_rd(mem_rd),
    .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { bit we; logic [WAW-1:0] addr; logic [NB-1:0] be; logic [DW-1:0] wdata; int cyc; } mexp_t;
  typedef struct { bit err; bit wen; logic [4:0] rd; logic [DW-1:0] data; int cyc; } rexp_t;

  mexp_t        mq[$];
  rexp_t        rq[$];
  byte unsigned ref_b[512];
  logic [DW-1:0] mem_w[128];
  int           errors = 0;
  int           checks = 0;
  int           sched_cyc = -1;
  logic [DW-1:0] sched_data = '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference: accesses judged on byte addresses, loads assembled from the byte array.
  task automatic model(input bit we, input logic [2:0] f3, input logic [AW-1:0] addr,
                       input logic [DW-1:0] wd, input logic [4:0] rd, input int acc,
                       input bit want_resp, output int rc);
    int     size;
    int     off;
    bit     bad;
    longint v;
    mexp_t  m;
    rexp_t  r;
    size = 1 << f3[1:0];
    off  = int'(addr) % NB;
    bad  = (f3 == 3'd7) || (f3 == 3'd3) || (f3 == 3'd6) || (we && f3[2]) || ((off % size) != 0);
    r.err = bad; r.wen = 1'b0; r.rd = rd; r.data = '0; r.cyc = acc + 1;
    if (!bad) begin
      m.we = we; m.addr = WAW'(int'(addr) / NB); m.be = '0; m.wdata = '0; m.cyc = acc + 1;
      for (int b = 0; b < NB; b++)
        if (b >= off && b < off + size) begin
          m.be[b] = 1'b1;
          m.wdata[8*b +: 8] = wd[8*(b-off) +: 8];
        end
      mq.push_back(m);
      if (we) begin
        for (int i = 0; i < size; i++) ref_b[int'(addr) + i] = wd[8*i +: 8];
        r.cyc = acc + 2;
      end else begin
        v = 0;
        for (int i = 0; i < size; i++) v = v | (longint'(ref_b[int'(addr) + i]) << (8 * i));
        if (!f3[2] && v[8*size-1]) v = v - (longint'(1) << (8 * size));
        r.data = v[DW-1:0];
        r.wen  = (rd != 5'd0);
        r.cyc  = acc + ML + 2;
      end
    end
    rc = r.cyc;
    if (want_resp) rq.push_back(r);
  endtask

  task automatic issue(input bit we, input logic [2:0] f3, input logic [AW-1:0] addr,
                       input logic [DW-1:0] wd, input logic [4:0] rd, input bit want_resp,
                       output int acc, output int rc);
    int n;
    n = 0;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd; req_rd = rd;
    #1;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!req_ready) chk("req_ready_timeout", 64'(req_ready), 64'(1));
    acc = cyc;
    model(we, f3, addr, wd, rd, acc, want_resp, rc);
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  // Monitor + memory responder
  initial begin
    mexp_t m;
    rexp_t r;
    forever begin
      @(negedge clk);
      if (mem_wr || mem_rd) begin
        if (mq.size() == 0) chk("mem_strobe_unexpected", 64'({mem_wr, mem_rd}), 64'(0));
        else begin
          m = mq.pop_front();
          chk("mem_cycle", 64'(cyc), 64'(m.cyc));
          chk("mem_wr", 64'(mem_wr), 64'(m.we));
          chk("mem_rd", 64'(mem_rd), 64'(!m.we));
          chk("mem_addr", 64'(mem_addr), 64'(m.addr));
          chk("mem_be", 64'(mem_be), 64'(m.be));
          chk("mem_wdata", 64'(mem_wdata), 64'(m.wdata));
        end
        if (mem_wr)
          for (int b = 0; b < NB; b++) if (mem_be[b]) mem_w[mem_addr][8*b +: 8] = mem_wdata[8*b +: 8];
        if (mem_rd) begin
          sched_cyc  = cyc + ML;
          sched_data = mem_w[mem_addr];
        end
      end else begin
        chk("mem_idle_zero", 64'({mem_addr, mem_be, mem_wdata}), 64'(0));
      end
      if (resp_valid) begin
        if (rq.size() == 0) chk("resp_unexpected", 64'(resp_valid), 64'(0));
        else begin
          r = rq.pop_front();
          chk("resp_cycle", 64'(cyc), 64'(r.cyc));
          chk("resp_err", 64'(resp_err), 64'(r.err));
          chk("resp_wen", 64'(resp_wen), 64'(r.wen));
          chk("resp_rd", 64'(resp_rd), 64'(r.rd));
          chk("resp_data", 64'(resp_data), 64'(r.data));
        end
      end else begin
        chk("resp_idle_zero", 64'({resp_wen, resp_err, resp_rd, resp_data}), 64'(0));
      end
      mem_rdata = (cyc == sched_cyc) ? sched_data : DW'($urandom);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, rc, prev, n;
    bit we;
    logic [2:0] f3;
    logic [AW-1:0] addr;
    for (int i = 0; i < 128; i++) begin
      mem_w[i] = DW'($urandom);
      for (int b = 0; b < NB; b++) ref_b[i*NB + b] = mem_w[i][8*b +: 8];
    end

    repeat (3) @(negedge clk);
    #1;
    chk("reset_req_ready", 64'(req_ready), 64'(0));
    chk("reset_busy", 64'(busy), 64'(0));
    chk("reset_strobes", 64'({mem_wr, mem_rd}), 64'(0));
    chk("reset_resp_valid", 64'(resp_valid), 64'(0));
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    #1 chk("ready_after_reset", 64'(req_ready), 64'(1));

    // LB of a 0x80 byte in lane 3
    mem_w[0] = 32'h8000_0000;
    ref_b[0] = 8'h00; ref_b[1] = 8'h00; ref_b[2] = 8'h00; ref_b[3] = 8'h80;
    issue(1'b0, 3'b000, 9'h003, 32'h0, 5'd7, 1'b1, acc, rc);
    issue(1'b1, 3'b001, 9'h006, 32'h1234_ABCD, 5'd3, 1'b1, acc, rc);
    issue(1'b0, 3'b010, 9'h002, 32'h0, 5'd9, 1'b1, acc, rc);
    issue(1'b0, 3'b011, 9'h008, 32'h0, 5'd0, 1'b1, acc, rc);
    issue(1'b0, 3'b100, 9'h006, 32'h0, 5'd2, 1'b1, acc, rc);

    // flush in the first WAIT cycle of an LBU
    issue(1'b0, 3'b100, 9'h011, 32'h0, 5'd4, 1'b0, acc, rc);
    @(negedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    #1;
    chk("flush_wait_ready", 64'(req_ready), 64'(1));
    chk("flush_wait_busy", 64'(busy), 64'(0));

    // flush in ACCESS of a store: write still lands, no response
    issue(1'b1, 3'b010, 9'h020, 32'hCAFE_F00D, 5'd0, 1'b0, acc, rc);
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    #1;
    chk("flush_access_ready", 64'(req_ready), 64'(1));
    issue(1'b0, 3'b010, 9'h020, 32'h0, 5'd6, 1'b1, acc, rc);

    // reset in WAIT
    issue(1'b0, 3'b010, 9'h040, 32'h0, 5'd5, 1'b0, acc, rc);
    @(negedge clk);
    @(negedge clk);
    #1 chk("busy_in_wait", 64'(busy), 64'(1));
    reset = 1'b0;
    #1;
    chk("rst_wait_busy", 64'(busy), 64'(0));
    chk("rst_wait_mem_rd", 64'(mem_rd), 64'(0));
    chk("rst_wait_resp_valid", 64'(resp_valid), 64'(0));
    chk("rst_wait_ready", 64'(req_ready), 64'(0));
    @(posedge clk);
    #2 reset = 1'b1;
    @(negedge clk);
    #1 chk("ready_after_release", 64'(req_ready), 64'(1));

    // randomized back-to-back traffic
    prev = 0;
    for (int i = 0; i < 150; i++) begin
      we   = 1'($urandom_range(0, 1));
      f3   = 3'($urandom_range(0, 7));
      addr = AW'($urandom_range(0, 511));
      if ($urandom_range(0, 3) != 0) addr = addr & ~(AW'((1 << f3[1:0]) - 1));
      issue(we, f3, addr, DW'($urandom), 5'($urandom_range(0, 31)), 1'b1, acc, rc);
      if (i > 0) chk("b2b_accept_cycle", 64'(acc), 64'(prev + 1));
      prev = rc;
    end

    n = 0;
    while ((mq.size() != 0 || rq.size() != 0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("mem_queue_drained", 64'(mq.size()), 64'(0));
    chk("resp_queue_drained", 64'(rq.size()), 64'(0));
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
